// File: rtl/decode_uop_serializer_pkg.sv
// Shared sizing, types and slot helpers for the decode micro-op serializer.
// RSD_DECODE_ONE_BRANCH_PER_CYCLE_EN (used by uop_slot_picker) limits emission to one branch per cycle.
package decode_uop_serializer_pkg;

    localparam int DECODE_WIDTH     = 2;
    localparam int MICRO_OP_MAX_NUM = 3;
    localparam int RENAME_WIDTH     = 2;

    localparam int FLAT_SLOTS = DECODE_WIDTH * MICRO_OP_MAX_NUM;
    localparam int CURSOR_W   = $clog2(FLAT_SLOTS + 1);
    localparam int INSN_W     = (DECODE_WIDTH > 1) ? $clog2(DECODE_WIDTH) : 1;

    typedef logic [15:0] OpInfo;
    typedef logic [31:0] PC_Path;

    typedef enum logic [1:0] {
        EMPTY,
        HOLD,
        SPLIT
    } SerializerState;

    typedef logic [CURSOR_W-1:0] SerializerCursor;

    function automatic logic [INSN_W-1:0] slot_insn(input SerializerCursor slot);
        return INSN_W'(int'(slot) / MICRO_OP_MAX_NUM);
    endfunction

    // A slot is the last of its instruction when no later slot of the same instruction is valid.
    function automatic logic is_last_uop(input logic [FLAT_SLOTS-1:0] mask,
                                         input SerializerCursor       slot);
        logic last;
        last = 1'b1;
        for (int j = 0; j < FLAT_SLOTS; j++) begin
            if (SerializerCursor'(j) > slot &&
                (j / MICRO_OP_MAX_NUM) == (int'(slot) / MICRO_OP_MAX_NUM) &&
                mask[j]) begin
                last = 1'b0;
            end
        end
        return last;
    endfunction

endpackage

// File: rtl/decode_uop_serializer_if.sv
// Bundle-in / micro-op-out bus of the decode serializer; master is pre-decode plus rename control,
// slave is the serializer.
interface decode_uop_serializer_if;
    import decode_uop_serializer_pkg::*;

    logic [DECODE_WIDTH-1:0] in_valid;
    logic [FLAT_SLOTS-1:0]   in_uop_valid;
    OpInfo                   in_uop [FLAT_SLOTS];
    PC_Path                  in_pc [DECODE_WIDTH];
    logic [FLAT_SLOTS-1:0]   in_is_branch;
    logic                    stall;
    logic                    clear;

    logic [RENAME_WIDTH-1:0] out_valid;
    OpInfo                   out_uop [RENAME_WIDTH];
    PC_Path                  out_pc [RENAME_WIDTH];
    logic [RENAME_WIDTH-1:0] out_last;
    logic                    hold_upstream;
    logic                    empty;

    modport master (
        output in_valid, in_uop_valid, in_uop, in_pc, in_is_branch, stall, clear,
        input  out_valid, out_uop, out_pc, out_last, hold_upstream, empty
    );

    modport slave (
        input  in_valid, in_uop_valid, in_uop, in_pc, in_is_branch, stall, clear,
        output out_valid, out_uop, out_pc, out_last, hold_upstream, empty
    );

endinterface

// File: rtl/decode_uop_serializer_uop_slot_picker.sv
// Picks the next RENAME_WIDTH valid flat slots at or after the cursor.
// With RSD_DECODE_ONE_BRANCH_PER_CYCLE_EN defined, selection stops before a second branch.
module uop_slot_picker
    import decode_uop_serializer_pkg::*;
(
    input  logic [FLAT_SLOTS-1:0]   valid_mask,
    input  logic [FLAT_SLOTS-1:0]   branch_mask,
    input  SerializerCursor         cursor,
    output SerializerCursor         sel_idx [RENAME_WIDTH],
    output logic [RENAME_WIDTH-1:0] lane_valid,
    output SerializerCursor         next_cursor,
    output logic                    exhausted
);

`ifdef RSD_DECODE_ONE_BRANCH_PER_CYCLE_EN
    localparam bit ONE_BRANCH_PER_CYCLE = 1'b1;
`else
    localparam bit ONE_BRANCH_PER_CYCLE = 1'b0;
`endif

    int   taken;
    logic stop;
    logic branch_taken;

    always_comb begin
        taken        = 0;
        stop         = 1'b0;
        branch_taken = 1'b0;
        next_cursor  = cursor;
        lane_valid   = '0;
        exhausted    = 1'b1;
        for (int l = 0; l < RENAME_WIDTH; l++) begin
            sel_idx[l] = '0;
        end

        for (int i = 0; i < FLAT_SLOTS; i++) begin
            if (!stop && SerializerCursor'(i) >= cursor && valid_mask[i]) begin
                if (taken == RENAME_WIDTH) begin
                    stop = 1'b1;
                end else if (ONE_BRANCH_PER_CYCLE && branch_mask[i] && branch_taken) begin
                    stop = 1'b1;
                end else begin
                    for (int l = 0; l < RENAME_WIDTH; l++) begin
                        if (l == taken) begin
                            sel_idx[l]    = SerializerCursor'(i);
                            lane_valid[l] = 1'b1;
                        end
                    end
                    taken        = taken + 1;
                    branch_taken = branch_taken | branch_mask[i];
                    next_cursor  = SerializerCursor'(i + 1);
                end
            end
        end

        // Anything valid left beyond the advanced cursor keeps the bundle alive.
        for (int i = 0; i < FLAT_SLOTS; i++) begin
            if (valid_mask[i] && SerializerCursor'(i) >= next_cursor) begin
                exhausted = 1'b0;
            end
        end
    end

endmodule

// File: rtl/decode_uop_serializer.sv
// Latches pre-decoded bundles and streams their valid micro-ops to rename, RENAME_WIDTH per cycle.
// Optional RSD_DECODE_ONE_BRANCH_PER_CYCLE_EN is applied inside uop_slot_picker.
module decode_uop_serializer
    import decode_uop_serializer_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst_n,
    decode_uop_serializer_if.slave bus
);

    SerializerState          state;
    SerializerCursor         cursor;
    logic [FLAT_SLOTS-1:0]   held_mask;
    logic [FLAT_SLOTS-1:0]   held_branch;
    OpInfo                   held_uop [FLAT_SLOTS];
    PC_Path                  held_pc [DECODE_WIDTH];

    logic [FLAT_SLOTS-1:0]   in_mask;
    SerializerCursor         sel_idx [RENAME_WIDTH];
    logic [RENAME_WIDTH-1:0] lane_valid;
    SerializerCursor         next_cursor;
    logic                    exhausted;
    logic                    busy;
    logic                    emit_ok;
    logic                    capture;

    always_comb begin
        in_mask = '0;
        for (int i = 0; i < FLAT_SLOTS; i++) begin
            in_mask[i] = bus.in_valid[slot_insn(SerializerCursor'(i))] & bus.in_uop_valid[i];
        end
    end

    uop_slot_picker picker (
        .valid_mask  (held_mask),
        .branch_mask (held_branch),
        .cursor      (cursor),
        .sel_idx     (sel_idx),
        .lane_valid  (lane_valid),
        .next_cursor (next_cursor),
        .exhausted   (exhausted)
    );

    assign busy              = (state != EMPTY);
    assign bus.hold_upstream = bus.stall | (busy & ~exhausted);
    assign capture           = ~bus.hold_upstream & ~bus.clear;
    assign emit_ok           = busy & ~bus.stall & ~bus.clear;
    assign bus.empty         = (state == EMPTY);

    always_comb begin
        bus.out_valid = lane_valid & {RENAME_WIDTH{emit_ok}};
        bus.out_last  = '0;
        for (int l = 0; l < RENAME_WIDTH; l++) begin
            bus.out_uop[l]  = held_uop[sel_idx[l]];
            bus.out_pc[l]   = held_pc[slot_insn(sel_idx[l])];
            bus.out_last[l] = is_last_uop(held_mask, sel_idx[l]);
        end
    end

    // clear beats capture and stall; a capture with no valid slot lands straight back in EMPTY.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= EMPTY;
            cursor      <= '0;
            held_mask   <= '0;
            held_branch <= '0;
        end else if (bus.clear) begin
            state     <= EMPTY;
            cursor    <= '0;
            held_mask <= '0;
        end else if (capture) begin
            state       <= (|in_mask) ? HOLD : EMPTY;
            cursor      <= '0;
            held_mask   <= in_mask;
            held_branch <= bus.in_is_branch;
        end else if (!bus.stall) begin
            state  <= SPLIT;
            cursor <= next_cursor;
        end
    end

    always_ff @(posedge clk) begin
        if (capture) begin
            held_uop <= bus.in_uop;
            held_pc  <= bus.in_pc;
        end
    end

endmodule

// File: tb/tb_decode_uop_serializer.sv
// Scoreboard bench for decode_uop_serializer: a queue-based model of the micro-op stream
// (honouring RSD_DECODE_ONE_BRANCH_PER_CYCLE_EN) feeds expectations to a negedge monitor.
module tb_decode_uop_serializer;
    import decode_uop_serializer_pkg::*;

`ifdef RSD_DECODE_ONE_BRANCH_PER_CYCLE_EN
    localparam bit ONE_BR = 1'b1;
`else
    localparam bit ONE_BR = 1'b0;
`endif

    typedef struct packed {
        logic hold;
        logic empty;
        logic emit;
    } CycleExp;

    typedef struct packed {
        logic [RENAME_WIDTH-1:0]  lanes;
        OpInfo [RENAME_WIDTH-1:0] uop;
        PC_Path [RENAME_WIDTH-1:0] pc;
        logic [RENAME_WIDTH-1:0]  last;
    } GroupExp;

    typedef struct packed {
        OpInfo  uop;
        PC_Path pc;
        logic   last;
        logic   br;
    } UopItem;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    decode_uop_serializer_if bus ();

    decode_uop_serializer dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int errors = 0;
    int checks = 0;
    int rem = 0;
    logic accepted;

    CycleExp cyc_q[$];
    GroupExp grp_q[$];

    logic [DECODE_WIDTH-1:0] b_valid;
    logic [FLAT_SLOTS-1:0]   b_uvalid;
    logic [FLAT_SLOTS-1:0]   b_br;
    OpInfo                   b_uop [FLAT_SLOTS];
    PC_Path                  b_pc [DECODE_WIDTH];

    task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic clearBundle();
        b_valid  = '0;
        b_uvalid = '0;
        b_br     = '0;
        for (int i = 0; i < FLAT_SLOTS; i++) b_uop[i] = OpInfo'(16'h1000 + i);
        for (int k = 0; k < DECODE_WIDTH; k++) b_pc[k] = PC_Path'(32'h8000 + 4 * k);
    endtask

    task automatic randomBundle();
        b_valid  = DECODE_WIDTH'($urandom);
        b_uvalid = FLAT_SLOTS'($urandom);
        for (int i = 0; i < FLAT_SLOTS; i++) begin
            b_uop[i] = OpInfo'($urandom);
            b_br[i]  = ($urandom_range(0, 99) < 30);
        end
        for (int k = 0; k < DECODE_WIDTH; k++) b_pc[k] = PC_Path'($urandom);
    endtask

    // Reference model: list the bundle's micro-ops in program order, then chop into per-cycle groups.
    task automatic buildGroups();
        UopItem  items[$];
        UopItem  it;
        GroupExp g;
        int      n;
        logic    br_in;
        items = {};
        for (int k = 0; k < DECODE_WIDTH; k++) begin
            if (b_valid[k]) begin
                for (int u = 0; u < MICRO_OP_MAX_NUM; u++) begin
                    if (b_uvalid[k * MICRO_OP_MAX_NUM + u]) begin
                        it.uop  = b_uop[k * MICRO_OP_MAX_NUM + u];
                        it.pc   = b_pc[k];
                        it.br   = b_br[k * MICRO_OP_MAX_NUM + u];
                        it.last = 1'b1;
                        for (int v = u + 1; v < MICRO_OP_MAX_NUM; v++)
                            if (b_uvalid[k * MICRO_OP_MAX_NUM + v]) it.last = 1'b0;
                        items.push_back(it);
                    end
                end
            end
        end
        rem = 0;
        while (items.size() > 0) begin
            g = '0;
            n = 0;
            br_in = 1'b0;
            while (n < RENAME_WIDTH && items.size() > 0) begin
                if (ONE_BR && items[0].br && br_in) break;
                it = items.pop_front();
                g.lanes[n] = 1'b1;
                g.uop[n]   = it.uop;
                g.pc[n]    = it.pc;
                g.last[n]  = it.last;
                br_in      = br_in | it.br;
                n++;
            end
            grp_q.push_back(g);
            rem++;
        end
    endtask

    // Drive one cycle, queue what the monitor must see in it, then advance the model at the edge.
    task automatic applyStimulus(input logic s, input logic c);
        CycleExp ce;
        bus.stall        = s;
        bus.clear        = c;
        bus.in_valid     = b_valid;
        bus.in_uop_valid = b_uvalid;
        bus.in_is_branch = b_br;
        bus.in_uop       = b_uop;
        bus.in_pc        = b_pc;
        ce.hold  = s | (rem > 1);
        ce.empty = (rem == 0);
        ce.emit  = !s && !c && (rem > 0);
        cyc_q.push_back(ce);
        @(posedge clk);
        #1;
        accepted = 1'b0;
        if (c) begin
            grp_q.delete();
            rem = 0;
        end else if (s) begin
            rem = rem;
        end else if (rem > 1) begin
            rem--;
        end else begin
            buildGroups();
            accepted = 1'b1;
        end
    endtask

    task automatic drainModel();
        clearBundle();
        for (int k = 0; k < 20 && rem > 0; k++) applyStimulus(1'b0, 1'b0);
    endtask

    CycleExp mon_ce;
    GroupExp mon_g;
    always @(negedge clk) begin
        if (cyc_q.size() > 0) begin
            mon_ce = cyc_q.pop_front();
            checkOutput("hold_upstream", 64'(bus.hold_upstream), 64'(mon_ce.hold));
            checkOutput("empty", 64'(bus.empty), 64'(mon_ce.empty));
            if (mon_ce.emit) begin
                checkOutput("group_available", 64'(grp_q.size() > 0), 64'd1);
                if (grp_q.size() > 0) begin
                    mon_g = grp_q.pop_front();
                    checkOutput("out_valid", 64'(bus.out_valid), 64'(mon_g.lanes));
                    for (int l = 0; l < RENAME_WIDTH; l++) begin
                        if (mon_g.lanes[l]) begin
                            checkOutput($sformatf("out_uop[%0d]", l), 64'(bus.out_uop[l]), 64'(mon_g.uop[l]));
                            checkOutput($sformatf("out_pc[%0d]", l), 64'(bus.out_pc[l]), 64'(mon_g.pc[l]));
                            checkOutput($sformatf("out_last[%0d]", l), 64'(bus.out_last[l]), 64'(mon_g.last[l]));
                        end
                    end
                end
            end else begin
                checkOutput("out_valid_idle", 64'(bus.out_valid), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        clearBundle();
        bus.stall        = 1'b0;
        bus.clear        = 1'b0;
        bus.in_valid     = '0;
        bus.in_uop_valid = '0;
        bus.in_is_branch = '0;
        bus.in_uop       = b_uop;
        bus.in_pc        = b_pc;
        accepted         = 1'b0;

        #12;
        checkOutput("reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("reset_empty", 64'(bus.empty), 64'd1);
        checkOutput("reset_hold", 64'(bus.hold_upstream), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        $display("[TB] two single-uop instructions");
        clearBundle();
        b_valid = 2'b11; b_uvalid = 6'b001_001;
        applyStimulus(1'b0, 1'b0);
        clearBundle();
        applyStimulus(1'b0, 1'b0);
        drainModel();

        $display("[TB] 3+1 micro-op split");
        b_valid = 2'b11; b_uvalid = 6'b001_111;
        applyStimulus(1'b0, 1'b0);
        clearBundle();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        drainModel();

        $display("[TB] stall in SPLIT");
        b_valid = 2'b11; b_uvalid = 6'b111_111;
        applyStimulus(1'b0, 1'b0);
        clearBundle();
        applyStimulus(1'b0, 1'b0);
        for (int k = 0; k < 3; k++) applyStimulus(1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        drainModel();

        $display("[TB] clear in SPLIT");
        b_valid = 2'b11; b_uvalid = 6'b111_111;
        applyStimulus(1'b0, 1'b0);
        clearBundle();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        drainModel();

        $display("[TB] two branches");
        b_valid = 2'b11; b_uvalid = 6'b001_001; b_br = 6'b001_001;
        applyStimulus(1'b0, 1'b0);
        clearBundle();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        drainModel();

        $display("[TB] randomized traffic");
        randomBundle();
        for (int cyc = 0; cyc < 300; cyc++) begin
            logic s, c;
            s = ($urandom_range(0, 99) < 15);
            c = ($urandom_range(0, 99) < 4);
            applyStimulus(s, c);
            if (accepted || c) randomBundle();
        end
        drainModel();
        applyStimulus(1'b0, 1'b0);
        checkOutput("no_leftover_groups", 64'(grp_q.size()), 64'd0);

        $display("[TB] asynchronous reset mid-bundle");
        b_valid = 2'b11; b_uvalid = 6'b111_111;
        applyStimulus(1'b0, 1'b0);
        clearBundle();
        applyStimulus(1'b0, 1'b0);
        bus.in_valid = '0;
        bus.stall    = 1'b0;
        bus.clear    = 1'b0;
        checkOutput("pre_reset_valid", 64'(bus.out_valid), 64'h3);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("async_reset_out_valid", 64'(bus.out_valid), 64'd0);
        checkOutput("async_reset_empty", 64'(bus.empty), 64'd1);
        checkOutput("async_reset_hold", 64'(bus.hold_upstream), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        grp_q.delete();
        rem = 0;

        b_valid = 2'b01; b_uvalid = 6'b000_011;
        applyStimulus(1'b0, 1'b0);
        clearBundle();
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0);
        checkOutput("final_no_leftover", 64'(grp_q.size()), 64'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/decode_uop_serializer.md
# decode_uop_serializer

Downstream neighbour of the pre-decode stage: it latches each pre-decoded bundle of DECODE_WIDTH instructions (up to MICRO_OP_MAX_NUM micro-ops each) and emits the valid micro-ops in program order, at most RENAME_WIDTH per cycle. While a bundle is only partly emitted, it holds the pre-decode stage. It is the point where multi-micro-op instructions are cracked into the per-cycle micro-op stream that feeds rename.

## Interface
- DECODE_WIDTH, 2, instructions per input bundle
- MICRO_OP_MAX_NUM, 3, micro-op slots per instruction
- RENAME_WIDTH, 2, micro-ops emitted per cycle
- clk  in  1  clock, rising edge
- rst_n  in  1  reset, asynchronous, active-low
- in_valid  in  DECODE_WIDTH  instruction slot valid
- in_uop_valid  in  DECODE_WIDTH*MICRO_OP_MAX_NUM  micro-op slot valid
- in_uop  in  DECODE_WIDTH*MICRO_OP_MAX_NUM x OpInfo  decoded micro-ops
- in_pc  in  DECODE_WIDTH x PC_Path  instruction PCs
- in_is_branch  in  DECODE_WIDTH*MICRO_OP_MAX_NUM  micro-op is a branch
- stall  in  1  downstream stall
- clear  in  1  flush
- out_valid  out  RENAME_WIDTH  output lane valid
- out_uop  out  RENAME_WIDTH x OpInfo  emitted micro-op
- out_pc  out  RENAME_WIDTH x PC_Path  PC of the parent instruction
- out_last  out  RENAME_WIDTH  last micro-op of its instruction
- hold_upstream  out  1  pre-decode must not advance
- empty  out  1  no micro-op pending

## Operation
- State machine: EMPTY (no bundle held), HOLD (bundle held, none emitted), SPLIT (bundle partly emitted).
- Flattened order: instruction index ascending, then micro-op index ascending. Slots with in_valid=0 or in_uop_valid=0 are skipped.
- Cursor: a flat slot index, width clog2(DECODE_WIDTH*MICRO_OP_MAX_NUM+1). Each cycle, the next up to RENAME_WIDTH valid slots at or after the cursor are selected. The cursor advances past the last selected slot.
- A bundle is exhausted when no valid slot remains at or after the advanced cursor.
- hold_upstream = stall OR (state≠EMPTY AND the bundle is not exhausted this cycle).
- A new bundle is captured when hold_upstream=0 and clear=0. The cursor resets to 0. Next state is HOLD if any slot is valid, else EMPTY.
- Exhausted with no new bundle: next state EMPTY.
- Partial emission: next state SPLIT.
- out_valid is forced to 0 when stall or clear is high. The cursor does not move under stall.
- clear: next state EMPTY; the held bundle is discarded, and any input presented that cycle is dropped. clear has priority over stall.
- out_last is 1 when no further valid micro-op of the same instruction follows the selected slot.
- empty = (state==EMPTY).

## Timing
- A bundle captured at edge N is emitted in cycle N+1 at the earliest. Output is combinational from the held registers.
- A bundle with k valid micro-ops, unstalled, occupies ceil(k/RENAME_WIDTH) cycles. hold_upstream is high in all but the last of those cycles.
- Reset (asynchronous, any time): state EMPTY, cursor 0, all out_valid 0, hold_upstream 0, empty 1. Held OpInfo/PC data registers are not reset.
- Asserting rst_n low mid-SPLIT abandons the remainder.
- The first edge after release accepts input normally.

## Configuration
- RSD_DECODE_ONE_BRANCH_PER_CYCLE_EN defined:
  - At most one micro-op with in_is_branch=1 is emitted per cycle.
  - Selection stops before a second branch, and that branch is emitted next cycle at lane 0.
- RSD_DECODE_ONE_BRANCH_PER_CYCLE_EN undefined: branches are unconstrained; selection is purely positional.

## Structure
- Shared package, existing decode types package:
  - SerializerState enum (EMPTY/HOLD/SPLIT).
  - Flat slot-count constant DECODE_WIDTH*MICRO_OP_MAX_NUM.
  - Cursor typedef.
- One sub-module, uop_slot_picker: combinational. Given a valid mask, branch mask and cursor, it returns RENAME_WIDTH selected slot indices, lane valids and the next cursor.

## Test plan
- Two single-uop instructions, no stall: emitted in one cycle one edge after capture; out_last=11; hold_upstream stays 0.
- Instructions with 3+1 uops, RENAME_WIDTH=2:
  - Cycle 1 emits insn0 uops 0,1 with hold_upstream=1.
  - Cycle 2 emits insn0 uop2 (out_last=1) and insn1 uop0; hold_upstream=0.
- stall asserted in SPLIT for 3 cycles: out_valid=0 throughout, cursor frozen; remainder emitted after release with no loss or duplication.
- clear during SPLIT: next cycle empty=1, out_valid=0; the remainder never appears.
- rst_n pulled low mid-bundle, asynchronously: outputs go to 0 and empty goes to 1 before the next clock edge.
- Macro defined, both uops of bundle are branches: lane 0 only in cycle 1, then second branch alone in cycle 2. Macro undefined: both in one cycle.
